// File: rtl/aes_const.sv
// Constants, key-size decode and FSM state type for the iterative AES forward engine.
package aes_const;

    localparam int unsigned NB     = 4;
    localparam int unsigned NR_MAX = 14;
    localparam int unsigned KW     = NB * (NR_MAX + 1);

    typedef enum logic [1:0] {AES128, AES192, AES256, AESRSV} aes_mode_e;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

    // Reserved mode falls back to AES-128.
    function automatic logic [3:0] nr_of(logic [1:0] mode);
        case (aes_mode_e'(mode))
            AES192:  return 4'd12;
            AES256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_wire.sv
// State / key-schedule / S-box types plus the SubBytes, ShiftRows and AddRoundKey primitives.
package aes_wire;

    import aes_const::*;

    typedef logic [4*NB-1:0][7:0] state_t;
    typedef logic [KW-1:0][31:0]  kexp_t;
    typedef logic [255:0][7:0]    sbox_t;

    function automatic state_t sub_bytes(state_t s, sbox_t sb);
        state_t o;
        for (int i = 0; i < 16; i++) begin
            o[4'(i)] = sb[s[4'(i)]];
        end
        return o;
    endfunction

    // Row r rotates left by r columns; byte index is 4*c+r.
    function automatic state_t shift_rows(state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(4*c + r)] = s[4'(4*((c + r) % 4) + r)];
            end
        end
        return o;
    endfunction

    // Word byte 0 (row 0) is the most significant byte of each key word.
    function automatic state_t add_round_key(state_t s, kexp_t k, logic [3:0] rnd);
        state_t      o;
        logic [31:0] w;
        for (int c = 0; c < 4; c++) begin
            w = k[{rnd, 2'(c)}];
            for (int r = 0; r < 4; r++) begin
                o[4'(4*c + r)] = s[4'(4*c + r)] ^ 8'(w >> (8*(3 - r)));
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_mcol.sv
// Combinational AES MixColumns over a 16-byte column-major state (GF(2^8), poly 0x11B).
module aes_mcol
    import aes_const::*;
    import aes_wire::*;
(
    input  state_t data,
    output state_t mixed
);

    function automatic logic [7:0] xtime(logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < NB; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data[4*c];
        assign a1 = data[4*c+1];
        assign a2 = data[4*c+2];
        assign a3 = data[4*c+3];
        assign mixed[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mixed[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mixed[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mixed[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/aes_fround_iter.sv
// Iterative AES-128/192/256 forward cipher, one round per clock with valid/ready handshakes.
// Define AES_FROUND_SBOX_REG_EN to register SubBytes and split each round over two cycles.
module aes_fround_iter
    import aes_const::*;
    import aes_wire::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] Mode,
    input  logic       In_valid,
    output logic       In_ready,
    input  state_t     State_in,
    input  kexp_t      KExp,
    input  sbox_t      SBox,
    output logic       Out_valid,
    input  logic       Out_ready,
    output state_t     State_out,
    output logic [3:0] Round
);

    fsm_e       fsm_q, fsm_d;
    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] nr_q, nr_d;
    logic       in_rdy;
    logic       last_round;
    state_t     sb_out, sr_out, mc_out, mix_out, rnd_out;

`ifdef AES_FROUND_SBOX_REG_EN
    logic   phase_q, phase_d;
    state_t sb_q, sb_d;
`endif

    assign sb_out = sub_bytes(state_q, SBox);
`ifdef AES_FROUND_SBOX_REG_EN
    assign sr_out = shift_rows(sb_q);
`else
    assign sr_out = shift_rows(sb_out);
`endif

    aes_mcol u_mcol (
        .data  (sr_out),
        .mixed (mc_out)
    );

    assign last_round = (round_q == nr_q);
    assign mix_out    = last_round ? sr_out : mc_out;
    assign rnd_out    = add_round_key(mix_out, KExp, round_q);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        in_rdy  = 1'b0;
`ifdef AES_FROUND_SBOX_REG_EN
        phase_d = phase_q;
        sb_d    = sb_q;
`endif
        unique case (fsm_q)
            StIdle: in_rdy = 1'b1;
            StBusy: begin
`ifdef AES_FROUND_SBOX_REG_EN
                phase_d = ~phase_q;
                if (!phase_q) begin
                    sb_d = sb_out;
                end else begin
                    state_d = rnd_out;
                    if (last_round) fsm_d = StDone;
                    else            round_d = round_q + 4'd1;
                end
`else
                state_d = rnd_out;
                if (last_round) fsm_d = StDone;
                else            round_d = round_q + 4'd1;
`endif
            end
            StDone: begin
                // Accepting alongside the output handshake avoids an IDLE bubble.
                in_rdy = Out_ready;
                if (Out_ready && !In_valid) fsm_d = StIdle;
            end
            default: fsm_d = StIdle;
        endcase

        if (In_valid && in_rdy) begin
            state_d = add_round_key(State_in, KExp, 4'd0);
            nr_d    = nr_of(Mode);
            round_d = 4'd1;
            fsm_d   = StBusy;
`ifdef AES_FROUND_SBOX_REG_EN
            phase_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            round_q <= '0;
            nr_q    <= 4'd10;
`ifdef AES_FROUND_SBOX_REG_EN
            phase_q <= 1'b0;
            sb_q    <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
`ifdef AES_FROUND_SBOX_REG_EN
            phase_q <= phase_d;
            sb_q    <= sb_d;
`endif
        end
    end

    assign In_ready  = in_rdy & ~reset;
    assign Out_valid = (fsm_q == StDone);
    assign State_out = state_q;
    assign Round     = round_q;

endmodule

// File: tb/tb_aes_fround_iter.sv
// Directed bench for aes_fround_iter: FIPS-197 C.1-C.3, backpressure, back-to-back, mid-run reset.
module tb_aes_fround_iter;

    import aes_const::*;
    import aes_wire::*;

`ifdef AES_FROUND_SBOX_REG_EN
    localparam int LatMul = 2;
`else
    localparam int LatMul = 1;
`endif

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] Mode;
    logic       In_valid, In_ready, Out_valid, Out_ready;
    state_t     State_in, State_out;
    kexp_t      KExp;
    sbox_t      SBox;
    logic [3:0] Round;

    int n_checks = 0;
    int n_fail   = 0;

    aes_fround_iter dut (
        .clock     (clock),
        .reset     (reset),
        .Mode      (Mode),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .State_in  (State_in),
        .KExp      (KExp),
        .SBox      (SBox),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .State_out (State_out),
        .Round     (Round)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic state_t to_state(logic [127:0] h);
        state_t s;
        for (int i = 0; i < 16; i++) s[i] = h[127-8*i -: 8];
        return s;
    endfunction

    function automatic logic [127:0] from_state(state_t s);
        logic [127:0] h;
        for (int i = 0; i < 16; i++) h[127-8*i -: 8] = s[i];
        return h;
    endfunction

    function automatic logic [31:0] sub_word(logic [31:0] w);
        return {SBox[w[31:24]], SBox[w[23:16]], SBox[w[15:8]], SBox[w[7:0]]};
    endfunction

    // FIPS-197 key expansion of the key 00 01 02 .. for the given mode.
    task automatic set_key(input int mode);
        int          nk, tot;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        nk  = (mode == 1) ? 6 : (mode == 2) ? 8 : 4;
        tot = 4 * (nk + 7);
        rc  = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < tot; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) KExp[i] = w[i];
    endtask

    // Present a block and return at the falling edge after it is accepted.
    task automatic send(input logic [1:0] m, input logic [127:0] pt);
        int g = 0;
        Mode     = m;
        State_in = to_state(pt);
        In_valid = 1'b1;
        while (!In_ready && g < 50) begin
            @(negedge clock);
            g++;
        end
        check_eq("accept_wait", 128'(g < 50), 128'd1);
        @(posedge clock);
        @(negedge clock);
        In_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!Out_valid && cycles < 100) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic pop();
        Out_ready = 1'b1;
        @(negedge clock);
        Out_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [1:0] m, input int nr,
                           input logic [127:0] exp);
        int cyc;
        send(m, PT);
        wait_out(cyc);
        check_eq({tag, "_lat"}, 128'(cyc), 128'(nr * LatMul));
        check_eq({tag, "_ct"}, from_state(State_out), exp);
    endtask

    initial begin
        logic [127:0] rows [16];
        int           cyc;
        int           g;
        rows = '{
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
        };
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) SBox[16*r + c] = rows[r][127-8*c -: 8];

        reset     = 1'b1;
        Mode      = 2'd0;
        In_valid  = 1'b0;
        Out_ready = 1'b0;
        State_in  = '0;
        set_key(0);
        repeat (2) @(negedge clock);
        check_eq("rst_in_ready", 128'(In_ready), 128'd0);
        check_eq("rst_out_valid", 128'(Out_valid), 128'd0);
        check_eq("rst_state_out", from_state(State_out), 128'd0);
        check_eq("rst_round", 128'(Round), 128'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("idle_in_ready", 128'(In_ready), 128'd1);

        // C.1 then hold off the consumer for five cycles
        run_one("c1", 2'd0, 10, C1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("bp_valid", 128'(Out_valid), 128'd1);
            check_eq("bp_ct", from_state(State_out), C1);
            check_eq("bp_in_ready", 128'(In_ready), 128'd0);
        end
        Out_ready = 1'b1;
        #1;
        check_eq("done_in_ready", 128'(In_ready), 128'd1);
        @(negedge clock);
        Out_ready = 1'b0;
        check_eq("hs_valid_low", 128'(Out_valid), 128'd0);
        check_eq("hs_idle_ready", 128'(In_ready), 128'd1);

        set_key(1);
        run_one("c2", 2'd1, 12, C2);
        pop();
        set_key(2);
        run_one("c3", 2'd2, 14, C3);
        pop();
        set_key(0);
        run_one("mode3", 2'd3, 10, C1);
        pop();

        // Back-to-back: C.3 accepted on the same edge as the C.1 output handshake
        set_key(0);
        Out_ready = 1'b1;
        send(2'd0, PT);
        In_valid = 1'b1;
        Mode     = 2'd2;
        wait_out(cyc);
        check_eq("b2b_lat1", 128'(cyc), 128'(10 * LatMul));
        check_eq("b2b_ct1", from_state(State_out), C1);
        check_eq("b2b_ready", 128'(In_ready), 128'd1);
        set_key(2);
        @(negedge clock);
        In_valid = 1'b0;
        check_eq("b2b_busy", 128'(Out_valid), 128'd0);
        check_eq("b2b_round", 128'(Round), LatMul == 1 ? 128'd1 : 128'd1);
        wait_out(cyc);
        check_eq("b2b_lat2", 128'(cyc), 128'(14 * LatMul));
        check_eq("b2b_ct2", from_state(State_out), C3);
        @(negedge clock);
        Out_ready = 1'b0;
        check_eq("b2b_drain", 128'(Out_valid), 128'd0);

        // Reset in the middle of C.1
        set_key(0);
        send(2'd0, PT);
        g = 0;
        while (Round != 4'd5 && g < 50) begin
            @(negedge clock);
            g++;
        end
        check_eq("reach_round5", 128'(g < 50), 128'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_valid", 128'(Out_valid), 128'd0);
        check_eq("mid_rst_round", 128'(Round), 128'd0);
        check_eq("mid_rst_state", from_state(State_out), 128'd0);
        check_eq("mid_rst_ready", 128'(In_ready), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", 128'(In_ready), 128'd1);
        @(negedge clock);
        run_one("c1_again", 2'd0, 10, C1);
        pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
